// File: rtl/cordic_iter_hs.sv
// ---------------------------------------------------------------------------
// cordic_iter_hs
//
// Iterative CORDIC engine with a valid/ready handshake on both sides. One
// operand set is processed at a time: it is quadrant-corrected (PRE), then
// rotated ITER times at one micro-rotation per clock (ROT), then gain
// compensated and saturated (SCALE). The result is held in DONE until the
// consumer takes it.
//
// Modes (sampled at accept):
//   mode = 0  rotation  : rotate (x,y) by angle z, z driven towards 0
//   mode = 1  vectoring : rotate (x,y) onto the +x axis, z accumulates angle
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   clr                   synchronous flush, aborts any transaction
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   mode                  0 = rotation, 1 = vectoring
//   x_in, y_in, z_in      signed Q(WIDTH-FRAC).FRAC operands, z in radians
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   x_out, y_out, z_out   signed results, same format as operands
//   ovf                   x_out or y_out saturated in the current result
//
// Latency: out_valid rises ITER+2 clocks after the accepting edge.
// ---------------------------------------------------------------------------
module cordic_iter_hs #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    ovf
);

  // x/y carry two guard integer bits so the CORDIC gain (~1.65) and the
  // vector growth of the first iterations cannot wrap before scaling.
  localparam int XW = WIDTH + 2;
  // Full product width of an XW-bit operand times a WIDTH-bit constant.
  localparam int PW = XW + WIDTH;
  // All angle/gain constants are stored with 30 fractional bits and
  // truncated down to FRAC bits.
  localparam int SH = 30 - FRAC;
  localparam int CW = 5;

  localparam logic [63:0] PI_RAW  = 64'h00000000_C90FDAA2;
  localparam logic [63:0] HPI_RAW = 64'h00000000_6487ED51;
  localparam logic [63:0] K_RAW   = 64'h00000000_26DD3B6A;

  localparam logic signed [WIDTH-1:0] PI_C   = WIDTH'(PI_RAW >> SH);
  localparam logic signed [WIDTH-1:0] HPI_C  = WIDTH'(HPI_RAW >> SH);
  localparam logic signed [WIDTH-1:0] NHPI_C = -HPI_C;
  localparam logic signed [WIDTH-1:0] K_C    = WIDTH'(K_RAW >> SH);

  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] RND_C   = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ROT,
    SCALE,
    DONE
  } state_t;

  state_t state;

  logic [CW-1:0]           cnt;
  logic                    mode_r;
  logic signed [XW-1:0]    x_r, y_r;
  logic signed [WIDTH-1:0] z_r;

  logic signed [XW-1:0]    x_pre, y_pre;
  logic signed [WIDTH-1:0] z_pre;

  logic signed [XW-1:0]    x_sh, y_sh, x_rot, y_rot;
  logic signed [WIDTH-1:0] z_rot, atan_v;
  logic                    dir_pos;

  logic signed [PW-1:0]    x_prod, y_prod, x_scl, y_scl;
  logic signed [WIDTH-1:0] x_sat, y_sat;
  logic                    x_ovf, y_ovf;

  // atan(2^-i) scaled by 2^30, truncated.
  function automatic logic [31:0] atan_raw(input logic [CW-1:0] i);
    case (i)
      5'd0:    atan_raw = 32'h3243F6A8;
      5'd1:    atan_raw = 32'h1DAC6705;
      5'd2:    atan_raw = 32'h0FADBAFC;
      5'd3:    atan_raw = 32'h07F56EA6;
      5'd4:    atan_raw = 32'h03FEAB76;
      5'd5:    atan_raw = 32'h01FFD55B;
      5'd6:    atan_raw = 32'h00FFFAAA;
      5'd7:    atan_raw = 32'h007FFF55;
      5'd8:    atan_raw = 32'h003FFFEA;
      5'd9:    atan_raw = 32'h001FFFFD;
      5'd10:   atan_raw = 32'h000FFFFF;
      5'd11:   atan_raw = 32'h0007FFFF;
      5'd12:   atan_raw = 32'h0003FFFF;
      5'd13:   atan_raw = 32'h0001FFFF;
      5'd14:   atan_raw = 32'h0000FFFF;
      5'd15:   atan_raw = 32'h00007FFF;
      5'd16:   atan_raw = 32'h00003FFF;
      5'd17:   atan_raw = 32'h00001FFF;
      5'd18:   atan_raw = 32'h00000FFF;
      5'd19:   atan_raw = 32'h000007FF;
      5'd20:   atan_raw = 32'h000003FF;
      5'd21:   atan_raw = 32'h000001FF;
      5'd22:   atan_raw = 32'h000000FF;
      5'd23:   atan_raw = 32'h0000007F;
      default: atan_raw = 32'h00000000;
    endcase
  endfunction

  // Clamp a scaled product into WIDTH bits; MSB of the result flags a clamp.
  function automatic logic [WIDTH:0] saturate(input logic signed [PW-1:0] v);
    if (v > SAT_MAX) begin
      saturate = {1'b1, SAT_MAX[WIDTH-1:0]};
    end else if (v < SAT_MIN) begin
      saturate = {1'b1, SAT_MIN[WIDTH-1:0]};
    end else begin
      saturate = {1'b0, v[WIDTH-1:0]};
    end
  endfunction

  // Quadrant pre-correction: a 180 degree flip brings the problem into the
  // +/- pi/2 convergence range of the micro-rotation sequence.
  always_comb begin
    x_pre = x_r;
    y_pre = y_r;
    z_pre = z_r;
    if (!mode_r) begin
      if (z_r > HPI_C) begin
        x_pre = -x_r;
        y_pre = -y_r;
        z_pre = z_r - PI_C;
      end else if (z_r < NHPI_C) begin
        x_pre = -x_r;
        y_pre = -y_r;
        z_pre = z_r + PI_C;
      end
    end else if (x_r[XW-1]) begin
      x_pre = -x_r;
      y_pre = -y_r;
      // The flip angle sign follows the original y so z lands near +/-pi.
      z_pre = y_r[XW-1] ? (z_r - PI_C) : (z_r + PI_C);
    end
  end

  // One micro-rotation for the current iteration index.
  always_comb begin
    atan_v  = WIDTH'(atan_raw(cnt) >> SH);
    x_sh    = x_r >>> cnt;
    y_sh    = y_r >>> cnt;
    dir_pos = mode_r ? y_r[XW-1] : ~z_r[WIDTH-1];
    if (dir_pos) begin
      x_rot = x_r - y_sh;
      y_rot = y_r + x_sh;
      z_rot = z_r - atan_v;
    end else begin
      x_rot = x_r + y_sh;
      y_rot = y_r - x_sh;
      z_rot = z_r + atan_v;
    end
  end

  // Gain compensation with round-half-up, then clamp to WIDTH bits.
  always_comb begin
    x_prod = PW'(x_r) * PW'(K_C);
    y_prod = PW'(y_r) * PW'(K_C);
    x_scl  = (x_prod + RND_C) >>> FRAC;
    y_scl  = (y_prod + RND_C) >>> FRAC;
    {x_ovf, x_sat} = saturate(x_scl);
    {y_ovf, y_sat} = saturate(y_scl);
  end

  // Control FSM and datapath registers. clr outranks every handshake;
  // result registers are only written on the SCALE -> DONE edge so the last
  // result stays visible after the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_r    <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_r      <= XW'(x_in);
            y_r      <= XW'(y_in);
            z_r      <= z_in;
            mode_r   <= mode;
            in_ready <= 1'b0;
            state    <= PRE;
          end
        end
        PRE: begin
          x_r   <= x_pre;
          y_r   <= y_pre;
          z_r   <= z_pre;
          cnt   <= '0;
          state <= ROT;
        end
        ROT: begin
          x_r <= x_rot;
          y_r <= y_rot;
          z_r <= z_rot;
          if (cnt == LAST_ITER) begin
            state <= SCALE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SCALE: begin
          x_out     <= x_sat;
          y_out     <= y_sat;
          z_out     <= z_r;
          ovf       <= x_ovf | y_ovf;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_hs.sv
// ---------------------------------------------------------------------------
// tb_cordic_iter_hs
//
// Directed bench for cordic_iter_hs at WIDTH=32, FRAC=24, ITER=16. A table
// of operand/expected-result records is pushed through the handshake, then
// hand-written sequences exercise backpressure, clr and rst_n mid-rotation.
// Expected values are hand-computed Q8.24 constants with a tolerance.
// ---------------------------------------------------------------------------
module tb_cordic_iter_hs;

  localparam int WIDTH = 32;
  localparam int FRAC  = 24;
  localparam int ITER  = 16;
  localparam int NVEC  = 11;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    clr;
  logic                    in_valid;
  logic                    in_ready;
  logic                    mode;
  logic signed [WIDTH-1:0] x_in, y_in, z_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] x_out, y_out, z_out;
  logic                    ovf;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        mode;
    logic [31:0] xi, yi, zi;
    logic [31:0] xe, ye, ze;
    int          xtol, ytol, ztol;
    logic        ovfe;
  } vec_t;

  vec_t vecs[NVEC];

  cordic_iter_hs #(
    .WIDTH(WIDTH),
    .FRAC (FRAC),
    .ITER (ITER)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .x_in     (x_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual,
                             input longint expected, input longint tol);
    longint diff;
    total++;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    if (diff <= tol) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) +/- %0d",
               name, actual, actual, expected, expected, tol);
    end
  endtask

  // Present one operand set, scramble the inputs after accept, and count
  // clocks until out_valid appears (bounded).
  task automatic applyStimulus(input vec_t v, output int lat);
    mode     = v.mode;
    x_in     = v.xi;
    y_in     = v.yi;
    z_in     = v.zi;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode     = ~v.mode;
    x_in     = 32'h1234_5678;
    y_in     = 32'h8765_4321;
    z_in     = 32'h0BAD_F00D;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) checkOutput("in_ready busy", longint'(in_ready), 0, 0);
    end
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " out_valid drop"}, longint'(out_valid), 0, 0);
    checkOutput({tag, " in_ready back"}, longint'(in_ready), 1, 0);
  endtask

  task automatic runVector(input int idx);
    int    lat;
    string tag;
    tag = $sformatf("v%0d", idx);
    applyStimulus(vecs[idx], lat);
    checkOutput({tag, " latency"}, longint'(lat), ITER + 2, 0);
    checkOutput({tag, " x_out"}, longint'(x_out), longint'($signed(vecs[idx].xe)), vecs[idx].xtol);
    checkOutput({tag, " y_out"}, longint'(y_out), longint'($signed(vecs[idx].ye)), vecs[idx].ytol);
    checkOutput({tag, " z_out"}, longint'(z_out), longint'($signed(vecs[idx].ze)), vecs[idx].ztol);
    checkOutput({tag, " ovf"}, longint'(ovf), longint'(vecs[idx].ovfe), 0);
    releaseResult(tag);
  endtask

  // Start a transaction, let it run a few ROT cycles, and return.
  task automatic startPartial(input int idx);
    mode     = vecs[idx].mode;
    x_in     = vecs[idx].xi;
    y_in     = vecs[idx].yi;
    z_in     = vecs[idx].zi;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic watchNoResult(input string name);
    int seen;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput(name, longint'(seen), 0, 0);
  endtask

  initial begin
    // mode, x_in, y_in, z_in, x_exp, y_exp, z_exp, tolerances, ovf_exp
    vecs[0]  = '{1'b0, 32'h01000000, 32'h00000000, 32'h00C90FDB,
                 32'h00B504F3, 32'h00B504F3, 32'h00000000, 1024, 1024, 1024, 1'b0};
    vecs[1]  = '{1'b1, 32'h03000000, 32'h04000000, 32'h00000000,
                 32'h05000000, 32'h00000000, 32'h00ED6338, 1024, 8192, 1024, 1'b0};
    vecs[2]  = '{1'b1, 32'hFF000000, 32'h00000000, 32'h00000000,
                 32'h01000000, 32'h00000000, 32'h03243F6A, 1024, 8192, 1024, 1'b0};
    vecs[3]  = '{1'b0, 32'h01000000, 32'h00000000, 32'h03243F6A,
                 32'hFF000000, 32'h00000000, 32'h00000000, 1024, 1024, 1024, 1'b0};
    vecs[4]  = '{1'b0, 32'h01000000, 32'h00000000, 32'h00000000,
                 32'h01000000, 32'h00000000, 32'h00000000, 1024, 1024, 1024, 1'b0};
    vecs[5]  = '{1'b0, 32'h00000000, 32'h01000000, 32'h01921FB5,
                 32'hFF000000, 32'h00000000, 32'h00000000, 1024, 1024, 1024, 1'b0};
    vecs[6]  = '{1'b0, 32'h01000000, 32'h00000000, 32'hFCDBC096,
                 32'hFF000000, 32'h00000000, 32'h00000000, 1024, 1024, 1024, 1'b0};
    vecs[7]  = '{1'b1, 32'h00000000, 32'h02000000, 32'h00000000,
                 32'h02000000, 32'h00000000, 32'h01921FB5, 1024, 8192, 1024, 1'b0};
    vecs[8]  = '{1'b1, 32'h7F000000, 32'h7F000000, 32'h00000000,
                 32'h7FFFFFFF, 32'h00000000, 32'h00C90FDB, 0, 262144, 2048, 1'b1};
    vecs[9]  = '{1'b1, 32'h01000000, 32'hFF000000, 32'h00000000,
                 32'h016A09E6, 32'h00000000, 32'hFF36F025, 1024, 8192, 1024, 1'b0};
    vecs[10] = '{1'b0, 32'h02000000, 32'h00000000, 32'hFF36F025,
                 32'h016A09E6, 32'hFE95F61A, 32'h00000000, 2048, 2048, 1024, 1'b0};

    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;

    #12;
    checkOutput("reset out_valid", longint'(out_valid), 0, 0);
    checkOutput("reset x_out", longint'(x_out), 0, 0);
    checkOutput("reset ovf", longint'(ovf), 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset in_ready", longint'(in_ready), 1, 0);

    for (int i = 0; i < NVEC; i++) begin
      runVector(i);
    end

    // Backpressure: result must stay put with out_ready low, even while a
    // new operand is being offered.
    begin
      int lat;
      applyStimulus(vecs[0], lat);
      checkOutput("bp latency", longint'(lat), ITER + 2, 0);
      mode     = 1'b1;
      x_in     = 32'h03000000;
      y_in     = 32'h04000000;
      z_in     = 32'h0;
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        checkOutput("bp out_valid held", longint'(out_valid), 1, 0);
        checkOutput("bp in_ready low", longint'(in_ready), 0, 0);
        checkOutput("bp x_out stable", longint'(x_out), longint'($signed(vecs[0].xe)), 1024);
        checkOutput("bp y_out stable", longint'(y_out), longint'($signed(vecs[0].ye)), 1024);
      end
      in_valid = 1'b0;
      releaseResult("bp");
      checkOutput("bp x_out kept", longint'(x_out), longint'($signed(vecs[0].xe)), 1024);
      watchNoResult("bp no phantom accept");
    end

    // clr mid-rotation discards the transaction.
    startPartial(1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checkOutput("clr in_ready", longint'(in_ready), 1, 0);
    checkOutput("clr out_valid", longint'(out_valid), 0, 0);
    watchNoResult("clr no result");
    runVector(3);

    // rst_n mid-rotation clears outputs immediately.
    startPartial(9);
    rst_n = 1'b0;
    #2;
    checkOutput("rst out_valid", longint'(out_valid), 0, 0);
    checkOutput("rst x_out", longint'(x_out), 0, 0);
    checkOutput("rst ovf", longint'(ovf), 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst in_ready", longint'(in_ready), 1, 0);
    watchNoResult("rst no result");
    runVector(8);
    runVector(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cordic_iter_hs.md
CORDIC_ITER_HS -- requirements
Module: cordic_iter_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning signed data width of x/y/z (legal 16..32).
REQ-002 SHALL have parameter FRAC, default 24, meaning fractional bits of x/y/z (legal 8..WIDTH-4).
REQ-003 SHALL have parameter ITER, default 16, meaning micro-rotations per transaction (legal 8..24).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr  input  1  synchronous flush; aborts any transaction.
REQ-007 SHALL have port in_valid  input  1  operand presented.
REQ-008 SHALL have port in_ready  output  1  block can accept operands.
REQ-009 SHALL have port mode  input  1  0 = rotation, 1 = vectoring; sampled at accept.
REQ-010 SHALL have ports x_in, y_in, z_in  input  WIDTH each  signed Q(WIDTH-FRAC).FRAC operands; z in radians.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have ports x_out, y_out, z_out  output  WIDTH each  signed results, same format as inputs.
REQ-014 SHALL have port ovf  output  1  x_out or y_out saturated in current result.

Function
REQ-015 SHALL implement FSM IDLE -> PRE -> ROT -> SCALE -> DONE -> IDLE.
REQ-016 SHALL assert in_ready only in IDLE; accept = in_valid & in_ready; accept captures x_in, y_in, z_in, mode and moves to PRE.
REQ-017 SHALL ignore input port changes while not in IDLE.
REQ-018 SHALL in PRE, rotation mode: if z > pi/2 then x,y negated, z -= pi; if z < -pi/2 then x,y negated, z += pi; else unchanged; one cycle.
REQ-019 SHALL in PRE, vectoring mode: if x < 0 then x,y negated and z += pi when y >= 0, z -= pi when y < 0; else unchanged; one cycle.
REQ-020 SHALL in ROT perform one micro-rotation per cycle for i = 0..ITER-1, iteration counter reset to 0 on entry to ROT.
REQ-021 SHALL choose direction d = +1 when z >= 0 (rotation) or y < 0 (vectoring), else -1; x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan(2^-i).
REQ-022 SHALL use arithmetic right shift; zero counts as non-negative.
REQ-023 SHALL hold x/y internally at WIDTH+2 bits (two guard integer bits), z at WIDTH bits with wrap-around.
REQ-024 SHALL hold atan(2^-i), i = 0..23, as elaboration constants at 30 fractional bits, truncated to FRAC bits; pi and pi/2 likewise.
REQ-025 SHALL in SCALE multiply x and y by K = 0.6072529350 (FRAC-bit constant), round half-up, saturate to WIDTH; set ovf if either saturates; z passes unscaled.
REQ-026 SHALL register results at the SCALE -> DONE edge; out_valid rises exactly ITER+2 cycles after the accept edge.
REQ-027 SHALL hold out_valid and x_out/y_out/z_out/ovf stable in DONE until out_ready = 1; DONE -> IDLE on that edge; no accept in the same cycle (max throughput one result per ITER+4 cycles).
REQ-028 SHALL keep last result on x_out/y_out/z_out/ovf after leaving DONE until next SCALE -> DONE edge; out_valid low outside DONE.
REQ-029 SHALL on clr = 1 go to IDLE next edge from any state, drop out_valid, discard transaction; clr has priority over accept and out_ready.
REQ-030 SHALL, for inputs with |x|,|y| <= 2^(WIDTH-FRAC-2), produce results within 2^-(ITER-2) of exact rotation/vectoring.

Reset
REQ-031 SHALL on rst_n = 0 immediately force state IDLE, counter 0, in_ready = 1 after release, out_valid = 0, ovf = 0, x_out = y_out = z_out = 0, including mid-transaction.

Verification
REQ-032 SHALL cover rotation: x=1.0 (0x01000000), y=0, z=pi/4 (0x00C90FDB) -> x_out = y_out = 0x00B504F3 +/-1024 LSB, out_valid 18 cycles after accept.
REQ-033 SHALL cover vectoring: x=3.0, y=4.0, z=0 -> x_out = 5.0 (0x05000000), y_out ~ 0, z_out = 0.927295 (0x00ED63383 >> 4, i.e. 0x00ED6338) +/-1024 LSB.
REQ-034 SHALL cover quadrant correction: vectoring x=-1.0, y=0 -> x_out = 1.0, z_out = +pi (0x03243F6A); rotation x=1.0, y=0, z=pi -> x_out = -1.0, y_out ~ 0.
REQ-035 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready = 0; out_ready = 1 -> IDLE next edge, in_ready = 1.
REQ-036 SHALL cover saturation: vectoring x=y=127.0 (WIDTH=32, FRAC=24) -> x_out = 0x7FFFFFFF, ovf = 1.
REQ-037 SHALL cover clr and rst_n asserted mid-ROT -> out_valid never rises for that transaction; next accepted operand produces correct result.
